rv32i_ctrl_fsm: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback over a shared single-port memory with a req/ack handshake. It drives the immediate-generator select, PC/IR/register-file write enables and datapath muxes from the opcode in the instruction register. It halts in a trap state on illegal opcode, ECALL/EBREAK or memory timeout.

---
 rtl/rv32i_pkg.sv | 55 +++++
 rtl/rv32i_ctrl_fsm_if.sv | 35 +++
 rtl/rv32i_opdec.sv | 33 +++
 rtl/rv32i_ctrl_fsm.sv | 194 +++++++++++++++++++
 tb/tb_rv32i_ctrl_fsm.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, datapath mux selects,
// FSM state codes and the opcode class produced by the decoder.
package rv32i_pkg;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcMisc   = 7'b0001111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    // Also consumed by the immediate generator.
    localparam logic [2:0] ImmNone = 3'b000;
    localparam logic [2:0] ImmI    = 3'b001;
    localparam logic [2:0] ImmU    = 3'b010;
    localparam logic [2:0] ImmS    = 3'b011;
    localparam logic [2:0] ImmB    = 3'b100;
    localparam logic [2:0] ImmJ    = 3'b101;

    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StTrap   = 3'd5;

    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluFunct  = 2'b01;
    localparam logic [1:0] AluBranch = 2'b10;
    localparam logic [1:0] AluPassB  = 2'b11;

    localparam logic [1:0] WbAlu = 2'b00;
    localparam logic [1:0] WbMem = 2'b01;
    localparam logic [1:0] WbPc4 = 2'b10;

    localparam logic [1:0] PcPlus4 = 2'b00;
    localparam logic [1:0] PcImm   = 2'b01;
    localparam logic [1:0] PcAlu   = 2'b10;

    localparam logic [1:0] TrapNone    = 2'b00;
    localparam logic [1:0] TrapIllegal = 2'b01;
    localparam logic [1:0] TrapTimeout = 2'b10;
    localparam logic [1:0] TrapSystem  = 2'b11;

    typedef enum logic [3:0] {
        ClsLui, ClsAuipc, ClsJal, ClsJalr, ClsBranch, ClsLoad, ClsStore,
        ClsOpImm, ClsOp, ClsFence, ClsSystem, ClsIllegal
    } op_class_e;

endpackage

// File: rtl/rv32i_ctrl_fsm_if.sv
// Control/handshake bundle between the control FSM (master) and the datapath/memory (slave).
interface rv32i_ctrl_fsm_if;
    logic [31:0] instr_i;
    logic        branch_taken_i;
    logic        mem_ack_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic        addr_sel_o;
    logic        ir_we_o;
    logic [2:0]  imm_sel_o;
    logic        alu_a_sel_o;
    logic        alu_b_sel_o;
    logic [1:0]  alu_op_o;
    logic        rf_we_o;
    logic [1:0]  wb_sel_o;
    logic        pc_we_o;
    logic [1:0]  pc_sel_o;
    logic        instr_ret_o;
    logic        trap_o;
    logic [1:0]  trap_cause_o;

    modport master (
        input  instr_i, branch_taken_i, mem_ack_i,
        output mem_req_o, mem_we_o, addr_sel_o, ir_we_o, imm_sel_o, alu_a_sel_o, alu_b_sel_o,
               alu_op_o, rf_we_o, wb_sel_o, pc_we_o, pc_sel_o, instr_ret_o, trap_o,
               trap_cause_o
    );

    modport slave (
        output instr_i, branch_taken_i, mem_ack_i,
        input  mem_req_o, mem_we_o, addr_sel_o, ir_we_o, imm_sel_o, alu_a_sel_o, alu_b_sel_o,
               alu_op_o, rf_we_o, wb_sel_o, pc_we_o, pc_sel_o, instr_ret_o, trap_o,
               trap_cause_o
    );
endinterface

// File: rtl/rv32i_opdec.sv
// Combinational opcode classifier: maps the IR opcode field to a class and immediate format.
module rv32i_opdec
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode_i,
    output op_class_e  cls_o,
    output logic [2:0] imm_sel_o,
    output logic       legal_o
);

    // Every listed opcode ends in 2'b11, so compressed/reserved encodings fall to default.
    always_comb begin
        cls_o     = ClsIllegal;
        imm_sel_o = ImmNone;
        case (opcode_i)
            OpcLui:    begin cls_o = ClsLui;    imm_sel_o = ImmU; end
            OpcAuipc:  begin cls_o = ClsAuipc;  imm_sel_o = ImmU; end
            OpcJal:    begin cls_o = ClsJal;    imm_sel_o = ImmJ; end
            OpcJalr:   begin cls_o = ClsJalr;   imm_sel_o = ImmI; end
            OpcLoad:   begin cls_o = ClsLoad;   imm_sel_o = ImmI; end
            OpcOpImm:  begin cls_o = ClsOpImm;  imm_sel_o = ImmI; end
            OpcStore:  begin cls_o = ClsStore;  imm_sel_o = ImmS; end
            OpcBranch: begin cls_o = ClsBranch; imm_sel_o = ImmB; end
            OpcOp:     cls_o = ClsOp;
            OpcMisc:   cls_o = ClsFence;
            OpcSystem: cls_o = ClsSystem;
            default:   ;
        endcase
    end

    assign legal_o = (cls_o != ClsIllegal);

endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/writeback over a shared req/ack memory,
// with a sticky trap state for illegal opcodes, ECALL/EBREAK and memory timeouts.
module rv32i_ctrl_fsm
    import rv32i_pkg::*;
#(
    parameter bit          TRAP_ON_ILLEGAL = 1'b1,
    parameter int unsigned ACK_TIMEOUT     = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    rv32i_ctrl_fsm_if.master ctrl_io
);

    localparam logic [15:0] TimeoutLim = ACK_TIMEOUT[15:0];

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  cause_q, cause_d;
    op_class_e   cls;
    logic [2:0]  imm_sel;
    logic        legal;
    logic        req;
    logic        ack;
    logic        timeout;
    logic        unused_instr;

    assign unused_instr = ^ctrl_io.instr_i[31:7];

    rv32i_opdec u_opdec (
        .opcode_i  (ctrl_io.instr_i[6:0]),
        .cls_o     (cls),
        .imm_sel_o (imm_sel),
        .legal_o   (legal)
    );

    assign req = (state_q == StFetch) || (state_q == StMem);
    assign ack = req && ctrl_io.mem_ack_i;

    // Counter only advances while a request is outstanding; ack beats a coincident timeout.
    always_comb begin
        cnt_d   = '0;
        timeout = 1'b0;
        if (req && !ack) begin
            cnt_d   = cnt_q + 16'd1;
            timeout = (ACK_TIMEOUT != 0) && (cnt_d == TimeoutLim);
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            StFetch: begin
                if (ack) begin
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StTrap;
                    cause_d = TrapTimeout;
                end
            end
            StDecode: begin
                if (cls == ClsSystem) begin
                    state_d = StTrap;
                    cause_d = TrapSystem;
                end else if (!legal && TRAP_ON_ILLEGAL) begin
                    state_d = StTrap;
                    cause_d = TrapIllegal;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (cls)
                    ClsBranch, ClsFence, ClsIllegal: state_d = StFetch;
                    ClsLoad, ClsStore:               state_d = StMem;
                    default:                         state_d = StWb;
                endcase
            end
            StMem: begin
                if (ack) begin
                    state_d = (cls == ClsLoad) ? StWb : StFetch;
                end else if (timeout) begin
                    state_d = StTrap;
                    cause_d = TrapTimeout;
                end
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            cause_q <= TrapNone;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Outputs are gated by rst_i so an in-flight request drops as soon as reset asserts.
    always_comb begin
        ctrl_io.mem_req_o    = 1'b0;
        ctrl_io.mem_we_o     = 1'b0;
        ctrl_io.addr_sel_o   = 1'b0;
        ctrl_io.ir_we_o      = 1'b0;
        ctrl_io.imm_sel_o    = ImmNone;
        ctrl_io.alu_a_sel_o  = 1'b0;
        ctrl_io.alu_b_sel_o  = 1'b0;
        ctrl_io.alu_op_o     = AluAdd;
        ctrl_io.rf_we_o      = 1'b0;
        ctrl_io.wb_sel_o     = WbAlu;
        ctrl_io.pc_we_o      = 1'b0;
        ctrl_io.pc_sel_o     = PcPlus4;
        ctrl_io.instr_ret_o  = 1'b0;
        ctrl_io.trap_o       = 1'b0;
        ctrl_io.trap_cause_o = cause_q;
        if (!rst_i) begin
            case (state_q)
                StFetch: begin
                    ctrl_io.mem_req_o = 1'b1;
                    ctrl_io.ir_we_o   = ack;
                end
                StDecode: ctrl_io.imm_sel_o = imm_sel;
                StExec: begin
                    ctrl_io.imm_sel_o = imm_sel;
                    case (cls)
                        ClsBranch: begin
                            ctrl_io.alu_op_o    = AluBranch;
                            ctrl_io.pc_we_o     = 1'b1;
                            ctrl_io.pc_sel_o    = ctrl_io.branch_taken_i ? PcImm : PcPlus4;
                            ctrl_io.instr_ret_o = 1'b1;
                        end
                        ClsFence, ClsIllegal: begin
                            ctrl_io.pc_we_o     = 1'b1;
                            ctrl_io.instr_ret_o = 1'b1;
                        end
                        ClsLoad, ClsStore: ctrl_io.alu_b_sel_o = 1'b1;
                        default: ;
                    endcase
                end
                StMem: begin
                    ctrl_io.imm_sel_o  = imm_sel;
                    ctrl_io.mem_req_o  = 1'b1;
                    ctrl_io.addr_sel_o = 1'b1;
                    ctrl_io.mem_we_o   = (cls == ClsStore);
                    if (ack && cls == ClsStore) begin
                        ctrl_io.pc_we_o     = 1'b1;
                        ctrl_io.instr_ret_o = 1'b1;
                    end
                end
                StWb: begin
                    ctrl_io.imm_sel_o   = imm_sel;
                    ctrl_io.rf_we_o     = 1'b1;
                    ctrl_io.pc_we_o     = 1'b1;
                    ctrl_io.instr_ret_o = 1'b1;
                    case (cls)
                        ClsOp:    ctrl_io.alu_op_o = AluFunct;
                        ClsOpImm: begin
                            ctrl_io.alu_op_o    = AluFunct;
                            ctrl_io.alu_b_sel_o = 1'b1;
                        end
                        ClsLui: begin
                            ctrl_io.alu_op_o    = AluPassB;
                            ctrl_io.alu_b_sel_o = 1'b1;
                        end
                        ClsAuipc: begin
                            ctrl_io.alu_a_sel_o = 1'b1;
                            ctrl_io.alu_b_sel_o = 1'b1;
                        end
                        ClsLoad: ctrl_io.wb_sel_o = WbMem;
                        ClsJal: begin
                            ctrl_io.wb_sel_o = WbPc4;
                            ctrl_io.pc_sel_o = PcImm;
                        end
                        ClsJalr: begin
                            ctrl_io.wb_sel_o    = WbPc4;
                            ctrl_io.pc_sel_o    = PcAlu;
                            ctrl_io.alu_b_sel_o = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StTrap:  ctrl_io.trap_o = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Bench for rv32i_ctrl_fsm: a per-instruction trace model predicts every output cycle for two
// parameterisations (trap-on-illegal/no-timeout and NOP-on-illegal/timeout=4).
module tb_rv32i_ctrl_fsm;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_we;
        logic [2:0] imm_sel;
        logic       alu_a;
        logic       alu_b;
        logic [1:0] alu_op;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       ret;
        logic       trap;
        logic [1:0] cause;
    } out_t;

    localparam int CLUI = 0, CAUIPC = 1, CJAL = 2, CJALR = 3, CBR = 4, CLD = 5, CST = 6;
    localparam int COPIMM = 7, COP = 8, CFENCE = 9, CSYS = 10, CILL = 11;

    logic        clk = 1'b0;
    logic        rst_a   [2];
    logic [31:0] instr_a [2];
    logic        ack_a   [2];
    logic        taken_a [2];
    out_t        outv    [2];
    out_t        q0[$];
    out_t        q1[$];
    out_t        ce;
    int          checks = 0;
    int          passes = 0;
    int          idx, ret_at, trap_at;

    always #5 clk = ~clk;

    rv32i_ctrl_fsm_if if0 ();
    rv32i_ctrl_fsm_if if1 ();

    rv32i_ctrl_fsm #(.TRAP_ON_ILLEGAL(1'b1), .ACK_TIMEOUT(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst_a[0]), .ctrl_io(if0)
    );
    rv32i_ctrl_fsm #(.TRAP_ON_ILLEGAL(1'b0), .ACK_TIMEOUT(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst_a[1]), .ctrl_io(if1)
    );

    assign if0.instr_i = instr_a[0];
    assign if0.mem_ack_i = ack_a[0];
    assign if0.branch_taken_i = taken_a[0];
    assign if1.instr_i = instr_a[1];
    assign if1.mem_ack_i = ack_a[1];
    assign if1.branch_taken_i = taken_a[1];

    assign outv[0] = {if0.mem_req_o, if0.mem_we_o, if0.addr_sel_o, if0.ir_we_o, if0.imm_sel_o,
                      if0.alu_a_sel_o, if0.alu_b_sel_o, if0.alu_op_o, if0.rf_we_o, if0.wb_sel_o,
                      if0.pc_we_o, if0.pc_sel_o, if0.instr_ret_o, if0.trap_o, if0.trap_cause_o};
    assign outv[1] = {if1.mem_req_o, if1.mem_we_o, if1.addr_sel_o, if1.ir_we_o, if1.imm_sel_o,
                      if1.alu_a_sel_o, if1.alu_b_sel_o, if1.alu_op_o, if1.rf_we_o, if1.wb_sel_o,
                      if1.pc_we_o, if1.pc_sel_o, if1.instr_ret_o, if1.trap_o, if1.trap_cause_o};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Single compare process: every predicted cycle is checked against the DUT mid-cycle.
    always @(negedge clk) begin
        if (q0.size() != 0) begin
            ce = q0.pop_front();
            chk($sformatf("dut0_cycle_t%0t", $time), {11'b0, outv[0]}, {11'b0, ce});
        end
        if (q1.size() != 0) begin
            ce = q1.pop_front();
            chk($sformatf("dut1_cycle_t%0t", $time), {11'b0, outv[1]}, {11'b0, ce});
        end
    end

    task automatic cyc(input int d, input logic ack, input out_t e);
        ack_a[d] = ack;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        idx++;
        @(negedge clk);
        if (outv[d].ret && ret_at == 0) ret_at = idx;
        if (outv[d].trap && trap_at == 0) trap_at = idx;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        rst_a[d] = 1'b1;
        ack_a[d] = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("dut%0d_reset_outputs", d), {11'b0, outv[d]}, 32'd0);
        rst_a[d] = 1'b0;
    endtask

    function automatic void classify(input logic [31:0] ins, output int c, output logic [2:0] imm);
        c = CILL;
        imm = 3'd0;
        case (ins[6:0])
            7'h37: begin c = CLUI;   imm = 3'd2; end
            7'h17: begin c = CAUIPC; imm = 3'd2; end
            7'h6f: begin c = CJAL;   imm = 3'd5; end
            7'h67: begin c = CJALR;  imm = 3'd1; end
            7'h03: begin c = CLD;    imm = 3'd1; end
            7'h13: begin c = COPIMM; imm = 3'd1; end
            7'h23: begin c = CST;    imm = 3'd3; end
            7'h63: begin c = CBR;    imm = 3'd4; end
            7'h33: c = COP;
            7'h0f: c = CFENCE;
            7'h73: c = CSYS;
            default: ;
        endcase
    endfunction

    // Halted: only trap/cause visible; an ack with no request must change nothing.
    task automatic trap_tail(input int d, input logic [1:0] cause);
        out_t e;
        for (int k = 0; k < 3; k++) begin
            e = '0;
            e.trap = 1'b1;
            e.cause = cause;
            cyc(d, 1'b1, e);
        end
    endtask

    // fw/mw: number of request cycles without ack before the acking cycle.
    task automatic run(input int d, input logic [31:0] ins, input logic tk, input int fw,
                       input int mw);
        int c;
        int tmo;
        logic [2:0] imm;
        logic ack;
        out_t e;
        tmo = (d == 0) ? 0 : 4;
        classify(ins, c, imm);
        instr_a[d] = ins;
        taken_a[d] = tk;
        idx = 0;
        ret_at = 0;
        trap_at = 0;
        for (int k = 0; k <= fw; k++) begin
            ack = (k == fw);
            e = '0;
            e.mem_req = 1'b1;
            e.ir_we = ack;
            cyc(d, ack, e);
            if (!ack && tmo != 0 && k + 1 == tmo) begin trap_tail(d, 2'b10); return; end
        end
        e = '0;
        e.imm_sel = imm;
        cyc(d, 1'b1, e);
        if (c == CSYS) begin trap_tail(d, 2'b11); return; end
        if (c == CILL && d == 0) begin trap_tail(d, 2'b01); return; end
        e = '0;
        e.imm_sel = imm;
        if (c == CBR || c == CFENCE || c == CILL) begin
            if (c == CBR) begin
                e.alu_op = 2'b10;
                e.pc_sel = tk ? 2'b01 : 2'b00;
            end
            e.pc_we = 1'b1;
            e.ret = 1'b1;
            cyc(d, 1'b0, e);
            return;
        end
        if (c == CLD || c == CST) begin
            e.alu_b = 1'b1;
            cyc(d, 1'b0, e);
            for (int k = 0; k <= mw; k++) begin
                ack = (k == mw);
                e = '0;
                e.imm_sel = imm;
                e.mem_req = 1'b1;
                e.addr_sel = 1'b1;
                e.mem_we = (c == CST);
                e.pc_we = ack && (c == CST);
                e.ret = ack && (c == CST);
                cyc(d, ack, e);
                if (!ack && tmo != 0 && k + 1 == tmo) begin trap_tail(d, 2'b10); return; end
            end
            if (c == CST) return;
        end else begin
            cyc(d, 1'b0, e);
        end
        e = '0;
        e.imm_sel = imm;
        e.rf_we = 1'b1;
        e.pc_we = 1'b1;
        e.ret = 1'b1;
        case (c)
            COP:    e.alu_op = 2'b01;
            COPIMM: begin e.alu_op = 2'b01; e.alu_b = 1'b1; end
            CLUI:   begin e.alu_op = 2'b11; e.alu_b = 1'b1; end
            CAUIPC: begin e.alu_a = 1'b1; e.alu_b = 1'b1; end
            CLD:    e.wb_sel = 2'b01;
            CJAL:   begin e.wb_sel = 2'b10; e.pc_sel = 2'b01; end
            CJALR:  begin e.wb_sel = 2'b10; e.pc_sel = 2'b10; e.alu_b = 1'b1; end
            default: ;
        endcase
        cyc(d, 1'b0, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        out_t e;
        for (int d = 0; d < 2; d++) begin
            rst_a[d] = 1'b1;
            instr_a[d] = 32'd0;
            ack_a[d] = 1'b0;
            taken_a[d] = 1'b0;
        end
        @(posedge clk);
        #1;

        // TRAP_ON_ILLEGAL=1, no timeout
        do_reset(0);
        run(0, 32'h0050_0093, 1'b0, 0, 0);
        chk("addi_retire_cycle", ret_at, 4);
        run(0, 32'h0000_0463, 1'b1, 0, 0);
        chk("beq_taken_retire_cycle", ret_at, 3);
        run(0, 32'h0000_0463, 1'b0, 0, 0);
        run(0, 32'h0000_2103, 1'b0, 0, 1);
        chk("lw_delay2_retire_cycle", ret_at, 6);
        run(0, 32'h0020_2223, 1'b0, 0, 0);
        chk("sw_retire_cycle", ret_at, 4);
        run(0, 32'h0000_10b7, 1'b0, 0, 0);
        run(0, 32'h0000_0097, 1'b0, 0, 0);
        run(0, 32'h0000_00ef, 1'b0, 1, 0);
        run(0, 32'h0000_8067, 1'b0, 0, 0);
        run(0, 32'h0020_81b3, 1'b0, 0, 0);
        run(0, 32'h0000_000f, 1'b0, 0, 0);
        run(0, 32'h0050_0093, 1'b0, 6, 0);
        run(0, 32'h0000_007f, 1'b0, 0, 0);
        chk("illegal_trap_no_retire", ret_at, 0);
        chk("illegal_trap_cycle", trap_at, 3);
        do_reset(0);
        run(0, 32'h0050_0091, 1'b0, 0, 0);
        do_reset(0);

        // Reset asserted in the second MEM cycle of a load.
        instr_a[0] = 32'h0000_2103;
        idx = 0;
        e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1;
        cyc(0, 1'b1, e);
        e = '0; e.imm_sel = 3'd1;
        cyc(0, 1'b0, e);
        e.alu_b = 1'b1;
        cyc(0, 1'b0, e);
        e = '0; e.imm_sel = 3'd1; e.mem_req = 1'b1; e.addr_sel = 1'b1;
        cyc(0, 1'b0, e);
        chk("mem_req_before_reset", {31'b0, outv[0].mem_req}, 32'd1);
        #2;
        rst_a[0] = 1'b1;
        #1;
        chk("mem_req_drops_on_reset", {31'b0, outv[0].mem_req}, 32'd0);
        chk("pc_we_low_in_reset", {31'b0, outv[0].pc_we}, 32'd0);
        @(posedge clk);
        #1;
        rst_a[0] = 1'b0;
        run(0, 32'h0000_0073, 1'b0, 0, 0);
        chk("ecall_cause", {30'b0, outv[0].cause}, 32'd3);
        chk("ecall_trap_cycle", trap_at, 3);
        rst_a[0] = 1'b1;

        // TRAP_ON_ILLEGAL=0, ACK_TIMEOUT=4
        do_reset(1);
        run(1, 32'h0000_007f, 1'b0, 0, 0);
        chk("illegal_nop_retire_cycle", ret_at, 3);
        run(1, 32'h0050_0093, 1'b0, 3, 0);
        chk("ack_on_4th_fetch_retire", ret_at, 7);
        run(1, 32'h0000_2103, 1'b0, 0, 3);
        run(1, 32'h0020_2223, 1'b0, 1, 2);
        run(1, 32'h0000_0463, 1'b1, 0, 0);
        run(1, 32'h0050_0093, 1'b0, 10, 0);
        chk("fetch_timeout_trap_cycle", trap_at, 5);
        chk("fetch_timeout_cause", {30'b0, outv[1].cause}, 32'd2);
        do_reset(1);
        run(1, 32'h0000_2103, 1'b0, 0, 10);
        chk("mem_timeout_trap_cycle", trap_at, 8);
        do_reset(1);
        run(1, 32'h0000_0073, 1'b0, 0, 0);

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
